// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Shared types and constants for the pong game sequencing logic.
//   - state_e   : game FSM state encoding (also exported on state_o)
//   - Win*      : encodings of the winner output
//   - Def*      : default parameter values for game_flow_ctrl
//   - sat_inc   : saturating 4-bit score increment
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StServe  = 3'd1,
        StPlay   = 3'd2,
        StPoint  = 3'd3,
        StOver   = 3'd4,
        StPaused = 3'd5
    } state_e;

    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinP1   = 2'b01;
    localparam logic [1:0] WinP2   = 2'b10;

    localparam int unsigned DefWinScore    = 9;
    localparam int unsigned DefServeFrames = 60;
    localparam int unsigned DefSyncStages  = 2;

    // Scores stop at the winning value instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
//   Multi-flop synchronizer for an asynchronous level input followed by a
//   rising-edge detector producing a single-cycle pulse.
//   Parameters:
//     Stages  : number of synchronizer flops (>= 1)
//   Ports:
//     clk_out : clock, rising edge
//     reset   : asynchronous, active-high
//     d_i     : raw level input
//     pulse_o : one-cycle pulse on a synchronized 0->1 transition
// -----------------------------------------------------------------------------
module edge_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_out,
    input  logic reset,
    input  logic d_i,
    output logic pulse_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    // Shift form works for any depth including a single flop.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | Stages'(d_i);
            prev_q <= sync_q[Stages-1];
        end
    end

    assign pulse_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//   Central game-sequencing FSM for the pong datapath. Owns both scores and
//   decides when the ball logic is held at centre, served, running or frozen.
//
//   Optional build macro: PAUSE_SUPPORT_EN adds a PAUSED state toggled by
//   pause_btn while in PLAY. Without it pause_btn is ignored.
//
//   Parameters:
//     WIN_SCORE    : score that ends the game (1..15)
//     SERVE_FRAMES : frame ticks the ball is held at centre before each serve
//     SYNC_STAGES  : synchronizer depth for the button and point inputs
//   Ports:
//     clk_out      : pixel clock, rising edge
//     reset        : asynchronous, active-high
//     frame_tick   : one-cycle strobe per frame (already in clk_out domain)
//     start_btn    : raw start/restart button level
//     p1_point_in  : level from ball logic, rises when P1 scores
//     p2_point_in  : level from ball logic, rises when P2 scores
//     pause_btn    : raw pause button level (PAUSE_SUPPORT_EN only)
//     ball_rst     : hold ball controller at centre
//     ball_en      : enable ball movement
//     serve_dir    : 0 = serve toward P1, 1 = toward P2
//     p1_score     : P1 score, binary
//     p2_score     : P2 score, binary
//     game_over    : high in OVER
//     winner       : 00 none, 01 P1, 10 P2
//     state_o      : current state encoding
// -----------------------------------------------------------------------------
module game_flow_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = DefWinScore,
    parameter int unsigned SERVE_FRAMES = DefServeFrames,
    parameter int unsigned SYNC_STAGES  = DefSyncStages
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       p1_point_in,
    input  logic       p2_point_in,
    input  logic       pause_btn,
    output logic       ball_rst,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    localparam int unsigned     CntW    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SERVE_FRAMES - 1);
    localparam logic [3:0]      WinVal  = 4'(WIN_SCORE);

    // -------------------------------------------------------------------------
    // Input synchronizers / edge detectors
    // -------------------------------------------------------------------------
    logic start_evt;
    logic p1_evt;
    logic p2_evt;

    edge_sync #(.Stages(SYNC_STAGES)) u_sync_start (
        .clk_out (clk_out),
        .reset   (reset),
        .d_i     (start_btn),
        .pulse_o (start_evt)
    );

    edge_sync #(.Stages(SYNC_STAGES)) u_sync_p1 (
        .clk_out (clk_out),
        .reset   (reset),
        .d_i     (p1_point_in),
        .pulse_o (p1_evt)
    );

    edge_sync #(.Stages(SYNC_STAGES)) u_sync_p2 (
        .clk_out (clk_out),
        .reset   (reset),
        .d_i     (p2_point_in),
        .pulse_o (p2_evt)
    );

`ifdef PAUSE_SUPPORT_EN
    logic pause_evt;

    edge_sync #(.Stages(SYNC_STAGES)) u_sync_pause (
        .clk_out (clk_out),
        .reset   (reset),
        .d_i     (pause_btn),
        .pulse_o (pause_evt)
    );
`else
    logic unused_pause_btn;
    assign unused_pause_btn = pause_btn;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      p1_q, p1_d;
    logic [3:0]      p2_q, p2_d;
    logic            dir_q, dir_d;
    logic [1:0]      win_q, win_d;
    logic            ball_rst_q;
    logic            ball_en_q;
    logic            game_over_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        dir_d   = dir_q;
        win_d   = win_q;

        unique case (state_q)
            StIdle: begin
                if (start_evt) begin
                    state_d = StServe;
                    cnt_d   = '0;
                end
            end

            StServe: begin
                if (frame_tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = StPlay;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            StPlay: begin
                // Point events take priority over a coincident pause request.
                if (p1_evt && p2_evt) begin
                    dir_d   = ~dir_q;
                    state_d = StPoint;
                end else if (p1_evt) begin
                    p1_d    = sat_inc(p1_q, WinVal);
                    dir_d   = 1'b1;
                    state_d = StPoint;
                end else if (p2_evt) begin
                    p2_d    = sat_inc(p2_q, WinVal);
                    dir_d   = 1'b0;
                    state_d = StPoint;
                end
`ifdef PAUSE_SUPPORT_EN
                else if (pause_evt) begin
                    state_d = StPaused;
                end
`endif
            end

            StPoint: begin
                if (p1_q == WinVal) begin
                    win_d   = WinP1;
                    state_d = StOver;
                end else if (p2_q == WinVal) begin
                    win_d   = WinP2;
                    state_d = StOver;
                end else begin
                    cnt_d   = '0;
                    state_d = StServe;
                end
            end

            StOver: begin
                if (start_evt) begin
                    p1_d    = '0;
                    p2_d    = '0;
                    win_d   = WinNone;
                    cnt_d   = '0;
                    state_d = StServe;
                end
            end

`ifdef PAUSE_SUPPORT_EN
            StPaused: begin
                if (pause_evt) begin
                    state_d = StPlay;
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state itself.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            dir_q       <= 1'b0;
            win_q       <= WinNone;
            ball_rst_q  <= 1'b1;
            ball_en_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            dir_q       <= dir_d;
            win_q       <= win_d;
            ball_rst_q  <= (state_d == StIdle) || (state_d == StServe) ||
                           (state_d == StPoint) || (state_d == StOver);
            ball_en_q   <= (state_d == StPlay);
            game_over_q <= (state_d == StOver);
        end
    end

    assign ball_rst  = ball_rst_q;
    assign ball_en   = ball_en_q;
    assign serve_dir = dir_q;
    assign p1_score  = p1_q;
    assign p2_score  = p2_q;
    assign game_over = game_over_q;
    assign winner    = win_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
`timescale 1ns/1ps
module tb_game_flow_ctrl;

    localparam logic [2:0] SI  = 3'd0;
    localparam logic [2:0] SS  = 3'd1;
    localparam logic [2:0] SP  = 3'd2;
    localparam logic [2:0] SPT = 3'd3;
    localparam logic [2:0] SO  = 3'd4;
`ifdef PAUSE_SUPPORT_EN
    localparam logic [2:0] SPA = 3'd5;
`endif

    logic       clk_out = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start_btn;
    logic       p1_point_in;
    logic       p2_point_in;
    logic       pause_btn;
    logic       ball_rst;
    logic       ball_en;
    logic       serve_dir;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state_o;

    always #5 clk_out = ~clk_out;

    game_flow_ctrl dut (
        .clk_out     (clk_out),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .p1_point_in (p1_point_in),
        .p2_point_in (p2_point_in),
        .pause_btn   (pause_btn),
        .ball_rst    (ball_rst),
        .ball_en     (ball_en),
        .serve_dir   (serve_dir),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .game_over   (game_over),
        .winner      (winner),
        .state_o     (state_o)
    );

    // Packed expectation: {state, ball_rst, ball_en, serve_dir, p1, p2, game_over, winner}
    typedef struct {
        string       name;
        logic        start;
        logic        p1;
        logic        p2;
        logic        pause;
        int          ticks;
        int          cycles;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [16:0] pk(input logic [2:0] st, input logic rst, input logic en,
                                       input logic sd, input logic [3:0] s1, input logic [3:0] s2,
                                       input logic go, input logic [1:0] w);
        return {st, rst, en, sd, s1, s2, go, w};
    endfunction

    function automatic vec_t mk(input string n, input logic st, input logic a, input logic b,
                                input logic pa, input int t, input int c, input logic [16:0] e);
        vec_t v;
        v.name = n; v.start = st; v.p1 = a; v.p2 = b; v.pause = pa;
        v.ticks = t; v.cycles = c; v.exp = e;
        return v;
    endfunction

    function automatic logic [16:0] outs();
        return {state_o, ball_rst, ball_en, serve_dir, p1_score, p2_score, game_over, winner};
    endfunction

    task automatic check(input string n, input logic [16:0] exp);
        logic [16:0] act;
        act = outs();
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", n, act, exp);
    endtask

    // Called at a negedge: set levels, issue ticks, idle cycles, then compare.
    task automatic apply(input vec_t v);
        start_btn   = v.start;
        p1_point_in = v.p1;
        p2_point_in = v.p2;
        pause_btn   = v.pause;
        for (int i = 0; i < v.ticks; i++) begin
            frame_tick = 1'b1;
            @(negedge clk_out);
            frame_tick = 1'b0;
        end
        repeat (v.cycles) @(negedge clk_out);
        check(v.name, v.exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Input edges reach the FSM three edges after the raw change (2 sync + 1).
        vecs.push_back(mk("reset",         0, 0, 0, 0,  0, 0, pk(SI,  1, 0, 0, 0, 0, 0, 2'b00)));
        vecs.push_back(mk("start_lat2",    1, 0, 0, 0,  0, 2, pk(SI,  1, 0, 0, 0, 0, 0, 2'b00)));
        vecs.push_back(mk("start_serve",   1, 0, 0, 0,  0, 1, pk(SS,  1, 0, 0, 0, 0, 0, 2'b00)));
        vecs.push_back(mk("serve_59",      0, 0, 0, 0, 59, 0, pk(SS,  1, 0, 0, 0, 0, 0, 2'b00)));
        vecs.push_back(mk("serve_60",      0, 0, 0, 0,  1, 0, pk(SP,  0, 1, 0, 0, 0, 0, 2'b00)));
        vecs.push_back(mk("p1_lat2",       0, 1, 0, 0,  0, 2, pk(SP,  0, 1, 0, 0, 0, 0, 2'b00)));
        vecs.push_back(mk("p1_point",      0, 1, 0, 0,  0, 1, pk(SPT, 1, 0, 1, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("p1_reserve",    0, 1, 0, 0,  0, 1, pk(SS,  1, 0, 1, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("p1_held_serve", 0, 1, 0, 0, 60, 0, pk(SP,  0, 1, 1, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("p1_held_play",  0, 1, 0, 0,  0, 5, pk(SP,  0, 1, 1, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("p1_release",    0, 0, 0, 0,  0, 3, pk(SP,  0, 1, 1, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("both_point",    0, 1, 1, 0,  0, 3, pk(SPT, 1, 0, 0, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("both_reserve",  0, 1, 1, 0,  0, 1, pk(SS,  1, 0, 0, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("both_serve",    0, 0, 0, 0, 60, 0, pk(SP,  0, 1, 0, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("start_in_play", 1, 0, 0, 0,  0, 4, pk(SP,  0, 1, 0, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("start_release", 0, 0, 0, 0,  0, 3, pk(SP,  0, 1, 0, 1, 0, 0, 2'b00)));
`ifndef PAUSE_SUPPORT_EN
        vecs.push_back(mk("pause_ignored", 0, 0, 0, 1,  0, 4, pk(SP,  0, 1, 0, 1, 0, 0, 2'b00)));
        vecs.push_back(mk("pause_release", 0, 0, 0, 0,  0, 3, pk(SP,  0, 1, 0, 1, 0, 0, 2'b00)));
`endif
        for (int k = 1; k <= 9; k++) begin
            vecs.push_back(mk("p2_point", 0, 0, 1, 0, 0, 3,
                              pk(SPT, 1, 0, 0, 4'd1, 4'(k), 0, 2'b00)));
            if (k < 9) begin
                vecs.push_back(mk("p2_reserve", 0, 0, 0, 0, 0, 1,
                                  pk(SS, 1, 0, 0, 4'd1, 4'(k), 0, 2'b00)));
                vecs.push_back(mk("p2_serve", 0, 0, 0, 0, 60, 0,
                                  pk(SP, 0, 1, 0, 4'd1, 4'(k), 0, 2'b00)));
            end else begin
                vecs.push_back(mk("game_over", 0, 0, 0, 0, 0, 1,
                                  pk(SO, 1, 0, 0, 4'd1, 4'd9, 1, 2'b10)));
            end
        end
        vecs.push_back(mk("over_p1_edge",  0, 1, 0, 0,  0, 4, pk(SO,  1, 0, 0, 1, 9, 1, 2'b10)));
        vecs.push_back(mk("over_p2_edge",  0, 0, 1, 0,  0, 4, pk(SO,  1, 0, 0, 1, 9, 1, 2'b10)));
        vecs.push_back(mk("over_release",  0, 0, 0, 0,  0, 4, pk(SO,  1, 0, 0, 1, 9, 1, 2'b10)));
        vecs.push_back(mk("restart",       1, 0, 0, 0,  0, 3, pk(SS,  1, 0, 0, 0, 0, 0, 2'b00)));
        vecs.push_back(mk("serve_cnt30",   0, 0, 0, 0, 30, 0, pk(SS,  1, 0, 0, 0, 0, 0, 2'b00)));

        reset       = 1'b1;
        frame_tick  = 1'b0;
        start_btn   = 1'b0;
        p1_point_in = 1'b0;
        p2_point_in = 1'b0;
        pause_btn   = 1'b0;
        repeat (3) @(negedge clk_out);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset mid-serve: outputs return before any clock edge.
        reset = 1'b1;
        #1;
        check("async_reset", pk(SI, 1, 0, 0, 0, 0, 0, 2'b00));
        @(negedge clk_out);
        reset = 1'b0;
        apply(mk("post_rst_start",  1, 0, 0, 0,  0, 3, pk(SS, 1, 0, 0, 0, 0, 0, 2'b00)));
        apply(mk("post_rst_59",     0, 0, 0, 0, 59, 0, pk(SS, 1, 0, 0, 0, 0, 0, 2'b00)));
        apply(mk("post_rst_60",     0, 0, 0, 0,  1, 0, pk(SP, 0, 1, 0, 0, 0, 0, 2'b00)));

`ifdef PAUSE_SUPPORT_EN
        apply(mk("pause_enter",     0, 0, 0, 1,  0, 3, pk(SPA, 0, 0, 0, 0, 0, 0, 2'b00)));
        apply(mk("pause_point_ign", 0, 1, 0, 1,  0, 4, pk(SPA, 0, 0, 0, 0, 0, 0, 2'b00)));
        apply(mk("pause_start_ign", 1, 0, 0, 0,  0, 4, pk(SPA, 0, 0, 0, 0, 0, 0, 2'b00)));
        apply(mk("pause_release",   0, 0, 0, 0,  0, 3, pk(SPA, 0, 0, 0, 0, 0, 0, 2'b00)));
        apply(mk("pause_resume",    0, 0, 0, 1,  0, 3, pk(SP,  0, 1, 0, 0, 0, 0, 2'b00)));
        apply(mk("resume_release",  0, 0, 0, 0,  0, 3, pk(SP,  0, 1, 0, 0, 0, 0, 2'b00)));
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
